// File: rtl/wishbone_arbiter.sv
`default_nettype none
// ============================================================================
// wishbone_arbiter : two-master round-robin Wishbone B3 arbiter with watchdog
// Revision         : 1.0
// ============================================================================
module wishbone_arbiter #(
  parameter int TGC_WIDTH = 3,
  parameter int TGA_WIDTH = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [31:0]          m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [TGA_WIDTH-1:0] m0_tga_i,
  input  logic [TGC_WIDTH-1:0] m0_tgc_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [31:0]          m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [TGA_WIDTH-1:0] m1_tga_i,
  input  logic [TGC_WIDTH-1:0] m1_tgc_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic                 m0_rty_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 m1_rty_o,
  output logic [31:0]          m_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [TGA_WIDTH-1:0] s_tga_o,
  output logic [TGC_WIDTH-1:0] s_tgc_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  localparam logic [1:0]           C_IDLE    = 2'd0;
  localparam logic [1:0]           C_GNT0    = 2'd1;
  localparam logic [1:0]           C_GNT1    = 2'd2;
  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic                 C_WDOG_EN = (TIMEOUT > 0);

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;   // 1 when m1 held the most recent grant
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 w_gnt0, w_gnt1, w_stb, w_term, w_fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= C_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? C_GNT0 : C_GNT1;
        else if (m0_cyc_i)        state_d = C_GNT0;
        else if (m1_cyc_i)        state_d = C_GNT1;
      end
      C_GNT0:  if (!m0_cyc_i) state_d = m1_cyc_i ? C_GNT1 : C_IDLE;
      C_GNT1:  if (!m1_cyc_i) state_d = m0_cyc_i ? C_GNT0 : C_IDLE;
      default: state_d = C_IDLE;
    endcase

    last_d = last_q;
    if (state_d == C_GNT0)      last_d = 1'b0;
    else if (state_d == C_GNT1) last_d = 1'b1;

    // Only an uninterrupted run of stalled strobes under one grant accumulates.
    if (!C_WDOG_EN || (state_d != state_q) || w_fire || !w_stb || w_term)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    w_gnt0  = (state_q == C_GNT0);
    w_gnt1  = (state_q == C_GNT1);
    grant_o = {w_gnt1, w_gnt0};

    w_term = s_ack_i | s_err_i | s_rty_i;
    w_stb  = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
    // A real termination arriving on the limit cycle wins over the watchdog.
    w_fire = C_WDOG_EN & (cnt_q == C_TIMEOUT) & w_stb & ~w_term;

    s_cyc_o = ((w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i)) & ~w_fire;
    s_stb_o = w_stb & ~w_fire;
    s_we_o  = (w_gnt0 & m0_we_i) | (w_gnt1 & m1_we_i);
    s_sel_o = ({4{w_gnt0}} & m0_sel_i) | ({4{w_gnt1}} & m1_sel_i);
    s_adr_o = ({32{w_gnt0}} & m0_adr_i) | ({32{w_gnt1}} & m1_adr_i);
    s_dat_o = ({32{w_gnt0}} & m0_dat_i) | ({32{w_gnt1}} & m1_dat_i);
    s_tga_o = ({TGA_WIDTH{w_gnt0}} & m0_tga_i) | ({TGA_WIDTH{w_gnt1}} & m1_tga_i);
    s_tgc_o = ({TGC_WIDTH{w_gnt0}} & m0_tgc_i) | ({TGC_WIDTH{w_gnt1}} & m1_tgc_i);

    m0_ack_o  = w_gnt0 & s_ack_i;
    m0_err_o  = w_gnt0 & (s_err_i | w_fire);
    m0_rty_o  = w_gnt0 & s_rty_i;
    m1_ack_o  = w_gnt1 & s_ack_i;
    m1_err_o  = w_gnt1 & (s_err_i | w_fire);
    m1_rty_o  = w_gnt1 & s_rty_i;
    m_dat_o   = s_dat_i;
    timeout_o = w_fire;
  end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
`default_nettype none
// Bench for wishbone_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against an ownership model.
module tb_wishbone_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cyc[2], stb[2], we[2];
  logic [3:0]  sel[2];
  logic [31:0] adr[2], dat[2];
  logic [1:0]  tga[2];
  logic [2:0]  tgc[2];
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;

  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  s_tga_o, grant_o;
  logic [2:0]  s_tgc_o;

  wishbone_arbiter #(.TGC_WIDTH(3), .TGA_WIDTH(2), .TIMEOUT(TO), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_tga_i(tga[0]), .m0_tgc_i(tgc[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_tga_i(tga[1]), .m1_tgc_i(tgc[1]),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_tga_o(s_tga_o), .s_tgc_o(s_tgc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ownership model: who holds the bus, who was served last, stalled-strobe run.
  bit mdl_busy, mdl_who, mdl_last = 1'b1;
  int mdl_stall;
  bit mdl_nb, mdl_nw, mdl_g, mdl_f;

  always_comb begin
    mdl_g  = mdl_busy ? stb[mdl_who] : 1'b0;
    mdl_f  = (TO > 0) && mdl_busy && (mdl_stall == TO) && mdl_g &&
             !(s_ack_i || s_err_i || s_rty_i);
    mdl_nb = mdl_busy;
    mdl_nw = mdl_who;
    if (!mdl_busy) begin
      if (cyc[0] && cyc[1])      begin mdl_nb = 1'b1; mdl_nw = ~mdl_last; end
      else if (cyc[0] || cyc[1]) begin mdl_nb = 1'b1; mdl_nw = cyc[1];    end
    end else if (!cyc[mdl_who]) begin
      if (cyc[~mdl_who]) mdl_nw = ~mdl_who;
      else               mdl_nb = 1'b0;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mdl_busy  <= 1'b0;
      mdl_who   <= 1'b0;
      mdl_last  <= 1'b1;
      mdl_stall <= 0;
    end else begin
      mdl_busy <= mdl_nb;
      mdl_who  <= mdl_nw;
      if (mdl_nb) mdl_last <= mdl_nw;
      if (mdl_nb != mdl_busy || mdl_nw != mdl_who || mdl_f || !mdl_g ||
          s_ack_i || s_err_i || s_rty_i)
        mdl_stall <= 0;
      else
        mdl_stall <= mdl_stall + 1;
    end
  end

  logic [1:0]  exp_grant;
  logic [73:0] exp_bus;
  logic        own0, own1;

  always @(negedge clock) begin
    own0      = mdl_busy && !mdl_who;
    own1      = mdl_busy &&  mdl_who;
    exp_grant = {own1, own0};
    exp_bus   = mdl_busy ? {we[mdl_who], sel[mdl_who], adr[mdl_who], dat[mdl_who],
                            tga[mdl_who], tgc[mdl_who]} : '0;
    check("grant/timeout", 128'({grant_o, timeout_o}), 128'({exp_grant, mdl_f}));
    check("slave bus",
          128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_tga_o, s_tgc_o}),
          128'({mdl_busy && cyc[mdl_who] && !mdl_f, mdl_g && !mdl_f, exp_bus}));
    check("master terms",
          128'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, m_dat_o}),
          128'({own0 && s_ack_i, own0 && (s_err_i || mdl_f), own0 && s_rty_i,
                own1 && s_ack_i, own1 && (s_err_i || mdl_f), own1 && s_rty_i, s_dat_i}));
  end

  initial begin
    int r;
    bit g;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = 4'hF;
      adr[k] = '0; dat[k] = '0; tga[k] = '0; tgc[k] = '0;
    end
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    #2 check("reset state", 128'({grant_o, s_cyc_o, s_stb_o, s_adr_o, timeout_o}), 128'(0));

    // Single master read
    tick();
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h7000_0004;
    #2 check("t1 no grant yet", 128'({grant_o, s_cyc_o}), 128'({2'b00, 1'b0}));
    tick();
    #2 check("t1 granted", 128'({grant_o, s_cyc_o, s_adr_o}), 128'({2'b01, 1'b1, 32'h7000_0004}));
    tick();
    tick(); s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #2 check("t1 ack", 128'({m0_ack_o, m1_ack_o, m_dat_o}), 128'({1'b1, 1'b0, 32'hDEAD_BEEF}));
    tick(); s_ack_i = 0; cyc[0] = 0; stb[0] = 0;
    tick(); tick();

    // Simultaneous request straight out of reset
    reset = 1;
    tick(); reset = 0;
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; we[1] = 1;
    dat[1] = 32'h1133_5577; adr[1] = 32'h0000_0100;
    tick(); s_ack_i = 1;
    #2 check("t2 m0 first", 128'(grant_o), 128'(2'b01));
    tick(); s_ack_i = 0; cyc[0] = 0; stb[0] = 0;
    #2 check("t2 hold on drop", 128'(grant_o), 128'(2'b01));
    tick(); s_ack_i = 1;
    #2 check("t2 handover", 128'({grant_o, s_we_o, s_dat_o}), 128'({2'b10, 1'b1, 32'h1133_5577}));
    tick(); s_ack_i = 0; cyc[1] = 0; stb[1] = 0; we[1] = 0;
    tick(); tick();

    // Round-robin with both masters always waiting
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      g = i[0];
      s_ack_i = 1;
      #2 check("t3 rr grant", 128'(grant_o), 128'(g ? 2'b10 : 2'b01));
      tick(); s_ack_i = 0; cyc[g] = 0; stb[g] = 0;
      tick(); cyc[g] = 1; stb[g] = 1;
    end
    cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
    tick(); tick();

    // Locked burst on m1 while m0 waits
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'h0000_2000;
    tick(); cyc[0] = 1; stb[0] = 1;
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1;
      #2 check("t4 burst grant", 128'({grant_o, m1_ack_o, m0_ack_o}), 128'({2'b10, 1'b1, 1'b0}));
      tick();
    end
    s_ack_i = 0; cyc[1] = 0; stb[1] = 0;
    #2 check("t4 release cycle", 128'(grant_o), 128'(2'b10));
    tick();
    #2 check("t4 m0 after burst", 128'(grant_o), 128'(2'b01));
    tick(); cyc[0] = 0; stb[0] = 0;
    tick(); tick();

    // Watchdog fires after TO stalled cycles
    cyc[0] = 1; stb[0] = 1;
    tick(); tick(); tick(); tick();
    #2 check("t5 before limit", 128'({m0_err_o, timeout_o, s_stb_o}), 128'({1'b0, 1'b0, 1'b1}));
    tick();
    #2 check("t5 fires", 128'({m0_err_o, timeout_o, s_cyc_o, s_stb_o, grant_o}),
             128'({1'b1, 1'b1, 1'b0, 1'b0, 2'b01}));
    tick();
    #2 check("t5 one pulse", 128'({m0_err_o, timeout_o, s_stb_o, grant_o}),
             128'({1'b0, 1'b0, 1'b1, 2'b01}));
    tick(); cyc[0] = 0; stb[0] = 0;
    tick(); tick();
    cyc[0] = 1; stb[0] = 1;
    repeat (5) tick();
    s_ack_i = 1; s_dat_i = 32'h0BAD_F00D;
    #2 check("t5 ack beats watchdog", 128'({m0_ack_o, m0_err_o, timeout_o, s_stb_o}),
             128'({1'b1, 1'b0, 1'b0, 1'b1}));
    tick(); s_ack_i = 0; cyc[0] = 0; stb[0] = 0;
    tick(); tick();

    // Asynchronous reset during an m1 transfer
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'hA5A5_0000;
    tick();
    #2 check("t6 pre-reset", 128'(grant_o), 128'(2'b10));
    reset = 1; s_ack_i = 1;
    #1 check("t6 async clear", 128'({grant_o, s_cyc_o, s_stb_o, s_adr_o, m1_ack_o, m0_ack_o}), 128'(0));
    tick(); s_ack_i = 0; cyc[0] = 1; stb[0] = 1; reset = 0;
    tick();
    #2 check("t6 m0 wins after reset", 128'(grant_o), 128'(2'b01));
    tick(); cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
    tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc[k]) begin
          if ($urandom_range(0, 5) == 0) begin cyc[k] = 0; stb[k] = 0; end
          else stb[k] = ($urandom_range(0, 3) != 0);
        end else if ($urandom_range(0, 2) == 0) begin
          cyc[k] = 1; stb[k] = 1;
        end
        we[k]  = 1'($urandom);
        sel[k] = 4'($urandom);
        adr[k] = $urandom;
        dat[k] = $urandom;
        tga[k] = 2'($urandom);
        tgc[k] = 3'($urandom);
      end
      s_dat_i = $urandom;
      g = mdl_busy ? stb[mdl_who] : 1'b0;
      r = int'($urandom_range(0, 99));
      s_ack_i = g && (r < 40);
      s_err_i = g && (r >= 40) && (r < 45);
      s_rty_i = g && (r >= 45) && (r < 50);
      tick();
    end
    cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
